// File: rtl/teller_dispatcher.sv
// teller_dispatcher: bank-queue sequencer with round-robin teller dispatch and service timers
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_tick              one-cycle timebase pulse for the service countdown
//   i_arrive            one-cycle pulse per arriving customer
//   i_teller_en         teller open switches
//   o_pcount            customers waiting
//   o_busy              teller serving a customer
//   o_assign_valid/id   registered dispatch pulse and the chosen teller
//   o_overflow          registered pulse when an arrival is dropped
//   o_empty, o_full     queue level alarms
//   o_wait_est          estimated wait in ticks, saturating at 31
module teller_dispatcher #(
  parameter int NUM_TELLERS   = 3,
  parameter int MAX_Q         = 9,
  parameter int SERVICE_TICKS = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_tick,
  input  logic                   i_arrive,
  input  logic [NUM_TELLERS-1:0] i_teller_en,
  output logic [3:0]             o_pcount,
  output logic [NUM_TELLERS-1:0] o_busy,
  output logic                   o_assign_valid,
  output logic [1:0]             o_assign_id,
  output logic                   o_overflow,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [4:0]             o_wait_est
);
  localparam logic [3:0] LQ  = 4'(MAX_Q);
  localparam logic [3:0] LT  = 4'(SERVICE_TICKS);
  localparam logic [7:0] LT8 = 8'(SERVICE_TICKS);
  logic [3:0]             r_pcount;
  logic [NUM_TELLERS-1:0] r_busy;
  logic [3:0]             r_timer [NUM_TELLERS];
  logic [1:0]             r_rr;
  logic                   r_valid;
  logic [1:0]             r_id;
  logic                   r_ovf;
  logic [3:0] w_elig;
  logic [1:0] w_k1, w_k2, w_id, w_rr_next, w_act;
  logic       w_disp, w_acc;
  logic [7:0] w_prod, w_quot;
  // Pad to four entries so a 2-bit index never points outside the vector.
  assign w_elig    = {1'b0, i_teller_en & ~r_busy};
  assign w_k1      = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
  assign w_k2      = (r_rr == 2'd0) ? 2'd2 : r_rr - 2'd1;
  assign w_disp    = (r_pcount != 4'd0) && (|w_elig);
  assign w_id      = w_elig[r_rr] ? r_rr : w_elig[w_k1] ? w_k1 : w_k2;
  assign w_rr_next = (w_id == 2'd2) ? 2'd0 : w_id + 2'd1;
  // A full queue still takes an arrival when a customer leaves in the same cycle.
  assign w_acc     = i_arrive && ((r_pcount < LQ) || w_disp);
  assign w_act     = {1'b0, i_teller_en[0]} + {1'b0, i_teller_en[1]} + {1'b0, i_teller_en[2]};
  assign w_prod    = {4'b0, r_pcount} * LT8;
  assign w_quot    = (w_act == 2'd1) ? w_prod : (w_act == 2'd2) ? (w_prod >> 1) : (w_prod / 8'd3);
  assign o_wait_est     = ((w_act == 2'd0) || (w_quot > 8'd31)) ? 5'd31 : w_quot[4:0];
  assign o_pcount       = r_pcount;
  assign o_busy         = r_busy;
  assign o_assign_valid = r_valid;
  assign o_assign_id    = r_id;
  assign o_overflow     = r_ovf;
  assign o_empty        = (r_pcount == 4'd0);
  assign o_full         = (r_pcount == LQ);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pcount <= '0;
      r_busy   <= '0;
      r_rr     <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < NUM_TELLERS; i++) r_timer[i] <= '0;
    end else begin
      r_pcount <= r_pcount + {3'b0, w_acc} - {3'b0, w_disp};
      r_ovf    <= i_arrive && !w_acc;
      r_valid  <= w_disp;
      if (w_disp) begin
        r_id <= w_id;
        r_rr <= w_rr_next;
      end
      // A freshly loaded timer takes priority over a coincident tick.
      for (int i = 0; i < NUM_TELLERS; i++) begin
        if (w_disp && (w_id == 2'(i))) begin
          r_timer[i] <= LT;
          r_busy[i]  <= 1'b1;
        end else if (i_tick && r_busy[i]) begin
          r_timer[i] <= r_timer[i] - 4'd1;
          if (r_timer[i] == 4'd1) r_busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_teller_dispatcher.sv
// tb_teller_dispatcher: table-driven scoreboard bench for teller_dispatcher
module tb_teller_dispatcher;
  typedef struct packed {
    logic       rst;
    logic       tick;
    logic       arr;
    logic [2:0] en;
    logic [3:0] pc;
    logic [2:0] busy;
    logic       val;
    logic [1:0] id;
    logic       ovf;
    logic [4:0] wt;
  } vec_t;
  typedef struct packed {
    logic [3:0] pc;
    logic [2:0] busy;
    logic       val;
    logic [1:0] id;
    logic       ovf;
    logic       emp;
    logic       full;
    logic [4:0] wt;
  } obs_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       arrive = 1'b0;
  logic [2:0] teller_en = 3'b000;
  logic [3:0] pcount;
  logic [2:0] busy;
  logic       assign_valid;
  logic [1:0] assign_id;
  logic       overflow, empty, full;
  logic [4:0] wait_est;
  int n_tests = 0;
  int n_fail = 0;
  vec_t tbl[$];
  obs_t exp_q[$];
  always #5 clk = ~clk;
  teller_dispatcher dut (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_arrive(arrive), .i_teller_en(teller_en),
    .o_pcount(pcount), .o_busy(busy), .o_assign_valid(assign_valid), .o_assign_id(assign_id),
    .o_overflow(overflow), .o_empty(empty), .o_full(full), .o_wait_est(wait_est)
  );
  function automatic vec_t v(logic r, logic t, logic a, logic [2:0] e, logic [3:0] p,
                             logic [2:0] b, logic vl, logic [1:0] i, logic o, logic [4:0] w);
    return '{rst:r, tick:t, arr:a, en:e, pc:p, busy:b, val:vl, id:i, ovf:o, wt:w};
  endfunction
  function automatic obs_t expect_of(vec_t x);
    return '{pc:x.pc, busy:x.busy, val:x.val, id:x.id, ovf:x.ovf,
             emp:(x.pc == 4'd0), full:(x.pc == 4'd9), wt:x.wt};
  endfunction
  task automatic check(string name);
    obs_t act, exp;
    act = '{pc:pcount, busy:busy, val:assign_valid, id:assign_id, ovf:overflow,
            emp:empty, full:full, wt:wait_est};
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got pc=%0d busy=%b", name, act.pc, act.busy);
      return;
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d busy=%b val=%b id=%0d ovf=%b emp=%b full=%b wt=%0d, want pc=%0d busy=%b val=%b id=%0d ovf=%b emp=%b full=%b wt=%0d",
               name, act.pc, act.busy, act.val, act.id, act.ovf, act.emp, act.full, act.wt,
               exp.pc, exp.busy, exp.val, exp.id, exp.ovf, exp.emp, exp.full, exp.wt);
    end
  endtask
  task automatic apply(vec_t x, string name);
    @(negedge clk);
    reset = x.rst;
    tick = x.tick;
    arrive = x.arr;
    teller_en = x.en;
    exp_q.push_back(expect_of(x));
    @(posedge clk);
    #1;
    check(name);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    // basic dispatch
    tbl.push_back(v(1,0,0,3'b111, 0,3'b000,0,0,0, 0));
    tbl.push_back(v(0,0,1,3'b111, 1,3'b000,0,0,0, 1));
    tbl.push_back(v(0,0,0,3'b111, 0,3'b001,1,0,0, 0));
    tbl.push_back(v(0,0,0,3'b111, 0,3'b001,0,0,0, 0));
    // round robin
    tbl.push_back(v(1,0,0,3'b111, 0,3'b000,0,0,0, 0));
    tbl.push_back(v(0,0,1,3'b111, 1,3'b000,0,0,0, 1));
    tbl.push_back(v(0,0,1,3'b111, 1,3'b001,1,0,0, 1));
    tbl.push_back(v(0,0,1,3'b111, 1,3'b011,1,1,0, 1));
    tbl.push_back(v(0,0,1,3'b111, 1,3'b111,1,2,0, 1));
    tbl.push_back(v(0,0,0,3'b111, 1,3'b111,0,2,0, 1));
    // service completion: all three finish on the 5th tick, then teller 0 wins
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,3'b111, 1,3'b111,0,2,0, 1));
    tbl.push_back(v(0,1,0,3'b111, 1,3'b000,0,2,0, 1));
    tbl.push_back(v(0,0,0,3'b111, 0,3'b001,1,0,0, 0));
    // capacity with no tellers open
    tbl.push_back(v(1,0,0,3'b000, 0,3'b000,0,0,0, 31));
    for (int k = 1; k <= 9; k++) tbl.push_back(v(0,0,1,3'b000, 4'(k),3'b000,0,0,0, 31));
    tbl.push_back(v(0,0,1,3'b000, 9,3'b000,0,0,1, 31));
    tbl.push_back(v(0,0,1,3'b010, 9,3'b010,1,1,0, 31));
    tbl.push_back(v(0,0,0,3'b010, 9,3'b010,0,1,0, 31));
    // disable while busy, re-enable, dispatch coinciding with a tick
    tbl.push_back(v(1,0,0,3'b001, 0,3'b000,0,0,0, 0));
    tbl.push_back(v(0,0,1,3'b001, 1,3'b000,0,0,0, 5));
    tbl.push_back(v(0,0,0,3'b001, 0,3'b001,1,0,0, 0));
    tbl.push_back(v(0,0,1,3'b000, 1,3'b001,0,0,0, 31));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,3'b000, 1,3'b001,0,0,0, 31));
    tbl.push_back(v(0,1,0,3'b000, 1,3'b000,0,0,0, 31));
    tbl.push_back(v(0,0,0,3'b000, 1,3'b000,0,0,0, 31));
    tbl.push_back(v(0,1,0,3'b001, 0,3'b001,1,0,0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,3'b001, 0,3'b001,0,0,0, 0));
    tbl.push_back(v(0,1,0,3'b001, 0,3'b000,0,0,0, 0));
    // build busy=011, pcount=4 ahead of the asynchronous reset
    tbl.push_back(v(1,0,0,3'b011, 0,3'b000,0,0,0, 0));
    tbl.push_back(v(0,0,1,3'b011, 1,3'b000,0,0,0, 2));
    tbl.push_back(v(0,0,1,3'b011, 1,3'b001,1,0,0, 2));
    tbl.push_back(v(0,0,1,3'b011, 1,3'b011,1,1,0, 2));
    tbl.push_back(v(0,0,1,3'b011, 2,3'b011,0,1,0, 5));
    tbl.push_back(v(0,0,1,3'b011, 3,3'b011,0,1,0, 7));
    tbl.push_back(v(0,0,1,3'b011, 4,3'b011,0,1,0, 10));
    reset = 1'b1;
    #12;
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));
    // mid-run reset: outputs must clear without waiting for a clock edge
    @(negedge clk);
    arrive = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.push_back('{pc:0, busy:3'b000, val:0, id:0, ovf:0, emp:1, full:0, wt:0});
    #1;
    check("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{pc:0, busy:3'b000, val:0, id:0, ovf:0, emp:1, full:0, wt:0});
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/teller_dispatcher.md
Name: teller_dispatcher

Overview:
- Sequences the bank-queue datapath.
- Holds the waiting-customer count and assigns each waiting customer to a free, enabled teller using round-robin arbitration.
- Runs a per-teller service countdown and publishes a wait estimate, plus empty/full alarms, for the seven-segment and LED path.
- Sits between the debounced arrival input, the teller switches and the display decoders.

Parameters:
- NUM_TELLERS, 3, number of tellers; the teller_en, busy and assign_id widths follow from it. Only the value 3 is supported.
- MAX_Q, 9, queue capacity; must be ≤ 15.
- SERVICE_TICKS, 5, service duration in tick pulses; must be 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- tick  in  1  one-cycle timebase pulse from the clock divider
- arrive  in  1  one-cycle pulse per arriving customer, already debounced and edge-detected
- teller_en  in  3  teller switches; bit i=1 means teller i is open
- pcount  out  4  customers waiting (registered)
- busy  out  3  teller i is serving a customer (registered)
- assign_valid  out  1  one-cycle pulse: a customer was dispatched
- assign_id  out  2  teller index for that dispatch; holds its last value otherwise
- overflow  out  1  one-cycle pulse: an arrival was dropped
- empty  out  1  pcount==0
- full  out  1  pcount==MAX_Q
- wait_est  out  5  estimated wait in ticks, saturating

Behaviour:
- Clock and reset: one clock is used. reset is asynchronous and active-high.
- Reset values: pcount=0, busy=0, all timers=0, rr_ptr=0, assign_valid=0, assign_id=0, overflow=0. Consequently empty=1 and full=0.
- Dispatch condition: evaluated each cycle from the registered state. A dispatch occurs when pcount>0 and some teller has teller_en[i]=1 and busy[i]=0.
- Arbitration: the winner is the first eligible teller scanning rr_ptr, rr_ptr+1, rr_ptr+2, wrapping modulo 3.
- Effects of a dispatch, at the clock edge:
  - busy[id]=1 and timer[id]=SERVICE_TICKS.
  - rr_ptr=(id+1) mod 3.
  - assign_valid=1 and assign_id=id, registered, so both are visible the cycle after the decision.
- Dispatch rate: at most one dispatch per cycle.
- Arrival: accepted if pcount<MAX_Q, or if a dispatch happens in the same cycle.
  - An accepted arrival increments pcount.
  - A rejected arrival leaves pcount unchanged and pulses overflow=1 for one cycle.
- Arrival and dispatch in the same cycle: pcount is unchanged.
- Latency: arrival at edge N with an idle enabled teller gives pcount=1 after N, a dispatch at N+1, pcount=0 and assign_valid=1 after N+1.
- Service timers: on tick, every busy teller's timer decrements by 1.
  - When a timer goes 1→0, busy[i] clears on that same edge.
  - That teller is eligible for dispatch from the next cycle.
  - A timer loaded by a dispatch on the current edge is not decremented by a simultaneous tick.
- Teller disabled while busy: the teller finishes its current service (the timer keeps running). It is not dispatched again until re-enabled. Re-enabling an idle teller makes it eligible on the next cycle.
- No teller enabled: pcount holds and no dispatch occurs.
- wait_est: combinational from the registered state, with act = popcount(teller_en).
  - act==0 gives 31.
  - Otherwise wait_est = floor(pcount*SERVICE_TICKS/act), saturated to 31.
- Reset mid-service: all service is abandoned and every register returns to its reset value immediately.

Test Plan:
- Basic dispatch: reset, teller_en=3'b111, one arrive pulse → pcount=1 for one cycle, then assign_valid=1 with assign_id=0, busy=3'b001, pcount=0, empty=1.
- Round robin: teller_en=3'b111, four arrivals on consecutive cycles, no ticks → assign_id sequence 0,1,2; busy=3'b111; pcount settles at 1; wait_est=floor(1*5/3)=1.
- Service completion: one teller busy with SERVICE_TICKS=5 → busy clears on the 5th tick pulse. If pcount=1 at that point, the next cycle dispatches to the next eligible teller in round-robin order.
- Capacity: teller_en=0, 10 arrivals → pcount=9, full=1, overflow pulses once on the 10th, wait_est=31. Then enable teller 1 while one more arrival lands on the dispatch cycle → arrival accepted, pcount stays 9, no overflow, assign_id=1.
- Disable while busy: clear teller 0's enable while it is busy → service completes after 5 ticks, and teller 0 is not reassigned while pcount>0.
- Mid-run reset: pulse reset while busy=3'b011 and pcount=4 → all outputs return to reset values asynchronously, with no assign_valid afterwards.
